// File: rtl/f16_pkg.sv
// Shared half-precision constants, classification helpers and the dot-product FSM state type.
package f16_pkg;

    localparam logic [4:0]  F16_EXP_MAX = 5'h1F;
    localparam logic [15:0] F16_QNAN    = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dot_state_t;

    function automatic logic f16_is_nan(input logic [15:0] v);
        return (v[14:10] == F16_EXP_MAX) && (v[9:0] != 10'd0);
    endfunction

    function automatic logic f16_is_inf(input logic [15:0] v);
        return (v[14:10] == F16_EXP_MAX) && (v[9:0] == 10'd0);
    endfunction

endpackage

// File: rtl/f16_fmac_normal_no_grs.sv
// Combinational f16 multiply-add result = x*y + z. Subnormal inputs and results flush to zero;
// alignment and normalisation truncate with no guard/round/sticky bits.
module f16_fmac_normal_no_grs
    import f16_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    output logic [15:0] result
);

    logic               w_x_zero, w_y_zero, w_z_zero;
    logic               w_x_inf, w_y_inf, w_z_inf;
    logic               w_sp;
    logic [21:0]        w_mp;
    logic [21:0]        w_mz;
    logic signed [9:0]  w_ep, w_ez;
    logic               w_p_big;
    logic [22:0]        w_big_m, w_small_m, w_small_al, w_sum;
    logic signed [9:0]  w_big_e, w_small_e, w_shift, w_res_e;
    logic               w_big_s, w_small_s, w_sum_s;
    logic [4:0]         w_p;
    logic [9:0]         w_frac;

    assign w_x_zero = (x[14:10] == 5'd0);
    assign w_y_zero = (y[14:10] == 5'd0);
    assign w_z_zero = (z[14:10] == 5'd0);
    assign w_x_inf  = f16_is_inf(x);
    assign w_y_inf  = f16_is_inf(y);
    assign w_z_inf  = f16_is_inf(z);
    assign w_sp     = x[15] ^ y[15];

    // Both significands carry their binary point at bit 20.
    assign w_mp = {1'b1, x[9:0]} * {1'b1, y[9:0]};
    assign w_mz = {1'b1, z[9:0], 10'd0};
    assign w_ep = $signed({5'd0, x[14:10]}) + $signed({5'd0, y[14:10]}) - 10'sd15;
    assign w_ez = $signed({5'd0, z[14:10]});

    always_comb begin
        w_p_big = w_z_zero || (w_ep >= w_ez);
        if (w_p_big) begin
            w_big_m   = {1'b0, w_mp};
            w_big_e   = w_ep;
            w_big_s   = w_sp;
            w_small_m = w_z_zero ? 23'd0 : {1'b0, w_mz};
            w_small_e = w_ez;
            w_small_s = z[15];
        end else begin
            w_big_m   = {1'b0, w_mz};
            w_big_e   = w_ez;
            w_big_s   = z[15];
            w_small_m = {1'b0, w_mp};
            w_small_e = w_ep;
            w_small_s = w_sp;
        end
        w_shift = w_big_e - w_small_e;
        if (w_shift > 10'sd22) w_small_al = 23'd0;
        else                   w_small_al = w_small_m >> w_shift[4:0];

        if (w_big_s == w_small_s) begin
            w_sum   = w_big_m + w_small_al;
            w_sum_s = w_big_s;
        end else if (w_big_m >= w_small_al) begin
            w_sum   = w_big_m - w_small_al;
            w_sum_s = w_big_s;
        end else begin
            w_sum   = w_small_al - w_big_m;
            w_sum_s = w_small_s;
        end

        w_p = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (w_sum[i]) w_p = 5'(i);
        end
        w_res_e = w_big_e + $signed({5'd0, w_p}) - 10'sd20;
        if (w_p >= 5'd10) w_frac = 10'(w_sum >> (w_p - 5'd10));
        else              w_frac = 10'(w_sum << (5'd10 - w_p));

        // NaN operands propagate quieted, z first; invalid operations yield the canonical qNaN.
        if (f16_is_nan(z)) begin
            result = z | 16'h0200;
        end else if (f16_is_nan(x)) begin
            result = x | 16'h0200;
        end else if (f16_is_nan(y)) begin
            result = y | 16'h0200;
        end else if ((w_x_inf && w_y_zero) || (w_y_inf && w_x_zero)) begin
            result = F16_QNAN;
        end else if (w_x_inf || w_y_inf) begin
            if (w_z_inf && (z[15] != w_sp)) result = F16_QNAN;
            else                            result = {w_sp, F16_EXP_MAX, 10'd0};
        end else if (w_z_inf) begin
            result = z;
        end else if (w_x_zero || w_y_zero) begin
            if (w_z_zero) result = {z[15] & w_sp, 15'd0};
            else          result = z;
        end else if (w_sum == 23'd0) begin
            result = 16'h0000;
        end else if (w_res_e > 10'sd30) begin
            result = {w_sum_s, F16_EXP_MAX, 10'd0};
        end else if (w_res_e < 10'sd1) begin
            result = {w_sum_s, 15'd0};
        end else begin
            result = {w_sum_s, w_res_e[4:0], w_frac};
        end
    end

endmodule

// File: rtl/f16_dot_acc.sv
// Streaming f16 dot-product accumulator: acc = z_init + sum(x*y), one FMAC step per accepted pair.
module f16_dot_acc
    import f16_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      z_init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic             out_nan,
    output logic             out_inf,
    output logic             busy
);

    dot_state_t       r_state;
    logic [15:0]      r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic             r_nan, r_inf;
    logic             r_in_ready, r_out_valid, r_busy;
    logic [15:0]      w_fmac;

    f16_fmac_normal_no_grs u_fmac (
        .x      (in_x),
        .y      (in_y),
        .z      (r_acc),
        .result (w_fmac)
    );

    // Handshake outputs are registered alongside the state so they never depend on inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= 16'd0;
            r_cnt       <= '0;
            r_nan       <= 1'b0;
            r_inf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc  <= z_init;
                        r_nan  <= f16_is_nan(z_init);
                        r_inf  <= f16_is_inf(z_init);
                        r_cnt  <= len;
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_state    <= RUN;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        r_acc <= w_fmac;
                        r_cnt <= r_cnt - 1'b1;
                        r_nan <= r_nan | f16_is_nan(w_fmac);
                        r_inf <= r_inf | f16_is_inf(w_fmac);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_acc;
    assign out_nan    = r_nan;
    assign out_inf    = r_inf;
    assign busy       = r_busy;

endmodule
